// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : RV32I load/store unit sitting directly after the ALU. It turns
//            one accepted memory op into a single request/grant/response
//            transaction on the data-memory port. Loads return aligned,
//            sign- or zero-extended data. Misaligned or illegal ops, and ops
//            that run past the timeout, return an error flag instead.
// Ports    : clk, rst_n               - clock, async active-low reset
//            req_valid_i/req_ready_o  - op handshake from control
//            req_we_i, req_funct3_i   - store flag and RV32I size/sign
//            req_addr_i, req_wdata_i  - effective address, store data (rs2)
//            rsp_valid_o/err/data     - one-cycle completion to writeback
//            mem_req_o/we/addr/be/wdata - data-memory request
//            mem_gnt_i, mem_rvalid_i, mem_rdata_i - memory grant and read data
// Revision : 1.0 - initial release
// ============================================================================
module lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic        rsp_err_o,
  output logic [31:0] rsp_data_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  // Counter is wide enough to hold TIMEOUT_CYCLES without wrapping, so a
  // grant on the last allowed cycle leaves the count at or above the limit.
  localparam int            c_CW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 2) : 1;
  localparam logic [c_CW-1:0] c_LIMIT = (TIMEOUT_CYCLES > 0) ? c_CW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     data_q, data_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            we_q, we_d;
  logic            err_q, err_d;
  logic [c_CW-1:0] cnt_q, cnt_d;

  logic            w_req_err;
  logic            w_expired;
  logic [31:0]     w_shifted;
  logic [31:0]     w_load_data;

  // Decode of the incoming op: illegal encodings or misaligned addresses.
  always_comb begin
    logic illegal;
    logic misalign;
    if (req_we_i) illegal = (req_funct3_i > 3'd2);
    else          illegal = (req_funct3_i == 3'd3) || (req_funct3_i == 3'd6) ||
                            (req_funct3_i == 3'd7);
    misalign  = ((req_funct3_i[1:0] == 2'd1) && req_addr_i[0]) ||
                ((req_funct3_i[1:0] == 2'd2) && (req_addr_i[1:0] != 2'b00));
    w_req_err = illegal || misalign;
  end

  assign w_expired = (TIMEOUT_CYCLES != 0) && (cnt_q >= c_LIMIT);

  // Bring the addressed byte/halfword down to bit 0, then extend.
  assign w_shifted = mem_rdata_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (funct3_q)
      3'd0:    w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'd1:    w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'd2:    w_load_data = w_shifted;
      3'd4:    w_load_data = {24'd0, w_shifted[7:0]};
      3'd5:    w_load_data = {16'd0, w_shifted[15:0]};
      default: w_load_data = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    err_d    = err_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          addr_d   = req_addr_i;
          wdata_d  = req_wdata_i;
          funct3_d = req_funct3_i;
          we_d     = req_we_i;
          err_d    = w_req_err;
          data_d   = '0;
          cnt_d    = '0;
          state_d  = w_req_err ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        if (mem_gnt_i) begin
          state_d = we_q ? S_RESP : S_WAIT_R;
        end else if (w_expired) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_WAIT_R: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        if (mem_rvalid_i) begin
          data_d  = w_load_data;
          state_d = S_RESP;
        end else if (w_expired) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      err_q    <= err_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs are decoded from state; memory fields are only driven in REQ so
  // everything reads 0 during reset and between transactions.
  always_comb begin
    logic in_req;
    logic in_resp;
    in_req      = (state_q == S_REQ);
    in_resp     = (state_q == S_RESP);
    // Reset forces state to IDLE, so ready is masked by rst_n to read 0.
    req_ready_o = rst_n && (state_q == S_IDLE);
    rsp_valid_o = in_resp;
    rsp_err_o   = in_resp && err_q;
    rsp_data_o  = in_resp ? data_q : '0;
    mem_req_o   = in_req;
    mem_we_o    = in_req && we_q;
    mem_addr_o  = in_req ? {addr_q[31:2], 2'b00} : '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (in_req) begin
      case (funct3_q[1:0])
        2'd0: begin
          mem_be_o    = 4'b0001 << addr_q[1:0];
          mem_wdata_o = {4{wdata_q[7:0]}};
        end
        2'd1: begin
          mem_be_o    = 4'b0011 << {addr_q[1], 1'b0};
          mem_wdata_o = {2{wdata_q[15:0]}};
        end
        default: begin
          mem_be_o    = 4'b1111;
          mem_wdata_o = wdata_q;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Purpose  : Self-checking bench for lsu. Directed scenarios followed by
//            randomized ops, each compared cycle by cycle with a reference
//            model that works from byte arithmetic on the address and data.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int total = 0;
  int bad   = 0;

  logic [3:0]  obs_be;
  logic [31:0] obs_wd;
  logic [31:0] obs_data;
  logic        obs_err;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_err_o    (rsp_err),
    .rsp_data_o   (rsp_data),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_be_o     (mem_be),
    .mem_wdata_o  (mem_wdata),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: op size in bytes, lane = byte offset in the word.
  function automatic void model(input bit we, input bit [2:0] f3, input bit [31:0] a,
                                input bit [31:0] wd, input bit [31:0] rd,
                                output bit err, output bit [3:0] be,
                                output bit [31:0] mwd, output bit [31:0] data);
    int nbytes;
    int lane;
    bit [31:0] mask;
    bit [31:0] v;
    lane   = int'(a % 32'd4);
    nbytes = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    if (we) err = (f3 > 2);
    else    err = (f3 == 3) || (f3 == 6) || (f3 == 7);
    if ((a % nbytes) != 0) err = 1'b1;
    be   = 4'(((1 << nbytes) - 1) << lane);
    mwd  = (nbytes == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
           (nbytes == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    v    = (rd >> (8 * lane)) & mask;
    if (f3 < 4 && nbytes < 4 && v >= (mask >> 1) + 32'd1) v = v | ~mask;
    data = (we || err) ? 32'd0 : v;
  endfunction

  // One complete op: gd = cycles of grant delay, rdl = cycles of rvalid delay.
  task automatic do_op(input bit we, input bit [2:0] f3, input bit [31:0] a,
                       input bit [31:0] wd, input bit [31:0] rd, input int gd, input int rdl);
    bit        e;
    bit [3:0]  be;
    bit [31:0] mwd;
    bit [31:0] d;
    int        cnt;
    bit        to;
    model(we, f3, a, wd, rd, e, be, mwd, d);
    cnt = 0;
    to  = 1'b0;
    chk("idle_ready", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    if (!e) begin
      for (int i = 0; i < 64; i++) begin
        chk("req_mem_req", {31'd0, mem_req}, 32'd1);
        chk("req_mem_we", {31'd0, mem_we}, {31'd0, we});
        chk("req_mem_addr", mem_addr, a & ~32'd3);
        chk("req_mem_be", {28'd0, mem_be}, {28'd0, be});
        chk("req_mem_wdata", mem_wdata, mwd);
        chk("req_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("req_ready_low", {31'd0, req_ready}, 32'd0);
        obs_be = mem_be;
        obs_wd = mem_wdata;
        if (i == gd) mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        cnt++;
        if (i == gd) break;
        if (cnt == 16) begin to = 1'b1; break; end
      end
      if (!we && !to) begin
        for (int j = 0; j < 64; j++) begin
          chk("wait_mem_req", {31'd0, mem_req}, 32'd0);
          chk("wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
          if (j == rdl) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rd;
          end
          @(posedge clk); #1;
          mem_rvalid = 1'b0;
          mem_rdata  = $urandom;
          cnt++;
          if (j == rdl) break;
          if (cnt == 16) begin to = 1'b1; break; end
        end
      end
    end
    if (to) begin
      e = 1'b1;
      d = 32'd0;
    end
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e});
    chk("rsp_data", rsp_data, d);
    chk("resp_mem_req", {31'd0, mem_req}, 32'd0);
    obs_err  = rsp_err;
    obs_data = rsp_data;
    @(posedge clk); #1;
    chk("rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);
    chk("ready_after", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd0);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_be"}, {28'd0, mem_be}, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
  endtask

  initial begin
    bit [2:0]  f3;
    bit [31:0] a;
    bit        we;
    int        nb;

    // Reset state
    #12;
    chk_all_zero("por");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("por_ready", {31'd0, req_ready}, 32'd1);

    // SW, zero-wait grant
    do_op(1'b1, 3'd2, 32'h0000_0104, 32'hDEAD_BEEF, 32'd0, 0, 0);
    chk("sw_be", {28'd0, obs_be}, 32'hF);
    chk("sw_wdata", obs_wd, 32'hDEAD_BEEF);
    chk("sw_err", {31'd0, obs_err}, 32'd0);
    chk("sw_data", obs_data, 32'd0);

    // LB / LBU from the top byte lane
    do_op(1'b0, 3'd0, 32'h0000_0203, 32'd0, 32'h8011_2233, 0, 0);
    chk("lb_be", {28'd0, obs_be}, 32'h8);
    chk("lb_data", obs_data, 32'hFFFF_FF80);
    do_op(1'b0, 3'd4, 32'h0000_0203, 32'd0, 32'h8011_2233, 0, 0);
    chk("lbu_data", obs_data, 32'h0000_0080);

    // SH with a 3-cycle grant delay
    do_op(1'b1, 3'd1, 32'h0000_0102, 32'h0000_ABCD, 32'd0, 3, 0);
    chk("sh_be", {28'd0, obs_be}, 32'hC);
    chk("sh_wdata", obs_wd, 32'hABCD_ABCD);
    chk("sh_err", {31'd0, obs_err}, 32'd0);

    // Error cases, no memory access
    do_op(1'b0, 3'd2, 32'h0000_0101, 32'd0, 32'd0, 0, 0);
    chk("lw_mis_err", {31'd0, obs_err}, 32'd1);
    do_op(1'b1, 3'd3, 32'h0000_0100, 32'h1234_5678, 32'd0, 0, 0);
    chk("st_f3_err", {31'd0, obs_err}, 32'd1);

    // Timeout with no grant, then grant in the last allowed REQ cycle
    do_op(1'b0, 3'd2, 32'h0000_0300, 32'd0, 32'd0, 1000, 0);
    chk("to_err", {31'd0, obs_err}, 32'd1);
    do_op(1'b0, 3'd2, 32'h0000_0300, 32'd0, 32'hCAFE_F00D, 15, 0);
    chk("late_gnt_err", {31'd0, obs_err}, 32'd0);
    chk("late_gnt_data", obs_data, 32'hCAFE_F00D);

    // Reset in WAIT_R
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h400;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rw_mem_req", {31'd0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_wait");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_wait_ready", {31'd0, req_ready}, 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("late_rvalid_rsp0", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("late_rvalid_rsp1", {31'd0, rsp_valid}, 32'd0);
    chk("late_rvalid_ready", {31'd0, req_ready}, 32'd1);

    // Reset in REQ: mem_req must drop without waiting for a clock
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h500;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rr_mem_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_req");
    @(negedge clk) rst_n = 1'b1;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    chk("late_gnt_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("late_gnt_ready", {31'd0, req_ready}, 32'd1);

    // Randomized ops; delays kept well inside the timeout window
    for (int k = 0; k < 40; k++) begin
      we = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (we) f3 = 3'($urandom_range(0, 2));
        else begin
          f3 = 3'($urandom_range(0, 4));
          if (f3 == 3'd3) f3 = 3'd5;
        end
        nb = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        a  = a - (a % nb);
      end
      do_op(we, f3, a, $urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
